// File: rtl/seq_mult8x8_core.sv
// Sequential shift-add unsigned multiplier core.
// One multiplier bit is consumed per clock. The product register and the done
// pulse feed the downstream 16-bit result register (done acts as its clk_en).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; abort takes priority and blocks acceptance
//   RUN   | one shift-add iteration per edge, WIDTH iterations in total
//   DONE  | single cycle with done=1; start is ignored, always back to IDLE
module seq_mult8x8_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               aclr,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] product_q;
  logic               done_q;
  logic               busy_q;

  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] acc_d;
  logic               last_d;

  // One iteration: conditional add into the upper half, keeping the carry,
  // then shift right with the carry entering at the top.
  always_comb begin
    sum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) begin
      sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end
    acc_d  = {sum_d, acc_q[WIDTH-1:1]};
    last_d = (count_q == CW'(WIDTH - 1));
  end

  // Control FSM with registered outputs; product only written on RUN->DONE.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (!abort && start) begin
            mcand_q <= multiplicand;
            acc_q   <= {{WIDTH{1'b0}}, multiplier};
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            count_q <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q   <= acc_d;
            count_q <= count_q + CW'(1);
            if (last_d) begin
              product_q <= acc_d;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (abort) begin
            count_q <= '0;
            acc_q   <= '0;
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult8x8_core.sv
// Directed bench for seq_mult8x8_core: latency, arithmetic corners,
// back-to-back operation, abort and asynchronous reset.
module tb_seq_mult8x8_core;

  logic        clk;
  logic        aclr;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks;
  int errors;

  seq_mult8x8_core #(.WIDTH(8)) dut (
    .clk          (clk),
    .aclr         (aclr),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in IDLE, #1 after an edge. Operands are scrambled during RUN.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string tag);
    start = 1'b1; multiplicand = a; multiplier = b;
    tick();
    check({tag, "_busy_acc"}, busy, 1);
    check({tag, "_done_acc"}, done, 0);
    start = 1'b0;
    multiplicand = 8'($urandom);
    multiplier   = 8'($urandom);
    for (int i = 1; i < 8; i++) begin
      tick();
      check({tag, "_done_run"}, done, 0);
      check({tag, "_busy_run"}, busy, 1);
    end
    tick();
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_done"}, busy, 1);
    check({tag, "_product"}, product, exp);
    tick();
    check({tag, "_done_after"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_product_hold"}, product, exp);
  endtask

  // Start an operation and abort it on RUN edge number n (1..8).
  task automatic abort_op(input int n, input logic [15:0] prev, input string tag);
    start = 1'b1; multiplicand = 8'd200; multiplier = 8'd100;
    tick();
    start = 1'b0;
    for (int i = 1; i < n; i++) begin
      tick();
      check({tag, "_done_run"}, done, 0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_product"}, product, prev);
    for (int i = 0; i < 3; i++) begin
      tick();
      check({tag, "_done_later"}, done, 0);
      check({tag, "_product_later"}, product, prev);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    aclr = 1'b0; start = 1'b0; abort = 1'b0;
    multiplicand = '0; multiplier = '0;

    // Reset then idle
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_product", product, 16'h0000);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
    end
    aclr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end

    run_op(8'd13, 8'd11, 16'd143, "basic");
    run_op(8'hFF, 8'hFF, 16'hFE01, "full");
    run_op(8'h80, 8'h02, 16'h0100, "carry");
    run_op(8'h00, 8'hFF, 16'h0000, "zero");
    run_op(8'd1, 8'd1, 16'd1, "one");

    // Back-to-back with start held high
    start = 1'b1; multiplicand = 8'd3; multiplier = 8'd5;
    tick();
    check("b2b1_busy", busy, 1);
    for (int i = 1; i < 8; i++) tick();
    check("b2b1_done_early", done, 0);
    tick();
    check("b2b1_done", done, 1);
    check("b2b1_product", product, 16'd15);
    multiplicand = 8'd7; multiplier = 8'd9;
    tick();
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_done", done, 0);
    tick();
    check("b2b2_busy", busy, 1);
    multiplicand = 8'hAA; multiplier = 8'h55;
    for (int i = 1; i < 8; i++) begin
      tick();
      check("b2b2_done_run", done, 0);
    end
    check("b2b2_product_hold", product, 16'd15);
    tick();
    check("b2b2_done", done, 1);
    check("b2b2_product", product, 16'd63);
    start = 1'b0;
    tick();
    tick();
    check("b2b_end_busy", busy, 0);

    // Abort
    run_op(8'd13, 8'd11, 16'd143, "prior");
    abort_op(4, 16'd143, "abort4");
    abort_op(8, 16'd143, "abort8");

    // Abort in IDLE beats start
    start = 1'b1; abort = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
    tick();
    check("abort_idle_busy", busy, 0);
    start = 1'b0; abort = 1'b0;
    tick();
    check("abort_idle_busy2", busy, 0);

    // Async reset mid-RUN
    start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 aclr = 1'b0;
    #1;
    check("arst_product", product, 16'h0000);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    tick();
    aclr = 1'b1;
    tick();
    check("arst_idle_busy", busy, 0);
    run_op(8'd6, 8'd7, 16'd42, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult8x8_core.md
Name: seq_mult8x8_core

Overview:
- Sequential shift-add unsigned multiplier core.
- Sits directly upstream of the 16-bit result register in the sequential 8x8 multiplier.
- Accepts two operands on a start strobe and iterates one multiplier bit per clock.
- Presents the 2*WIDTH-bit product with a one-cycle done pulse; done drives the result register's clk_en.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits and the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- aclr  input  1  reset, asynchronous, active-low; clears all state immediately when low.
- start  input  1  request a multiplication; sampled only in IDLE.
- multiplicand  input  WIDTH  operand A; latched on the accepting edge.
- multiplier  input  WIDTH  operand B; latched on the accepting edge.
- abort  input  1  synchronous cancel of an in-flight operation.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse; product is valid and new.
- product  output  2*WIDTH  result; holds its value until the next completion.

Behaviour:
- Reset (aclr low, asynchronous):
  - state=IDLE, count=0, internal accumulator=0, operand registers=0.
  - product=0, done=0, busy=0.
  - Release is synchronous to clk; the first active edge after release operates normally.
- States: IDLE, RUN, DONE.
  - IDLE:
    - If start=1 at an edge, latch multiplicand into mcand.
    - Load accumulator = {WIDTH zeros, multiplier}; set count=0; go to RUN.
    - Otherwise stay in IDLE.
  - RUN: each edge performs one iteration.
    - If acc[0]=1, the upper half becomes acc_hi + mcand, computed in WIDTH+1 bits. The carry becomes the new MSB after the shift.
    - The accumulator then shifts right by 1, with the carry shifted in at the top.
    - count increments each iteration.
    - On the iteration where count=WIDTH-1: load product with the final accumulator value, assert done, go to DONE.
  - DONE: one cycle only, with done=1. The next edge goes to IDLE unconditionally; start is ignored in this cycle.
- Latency:
  - Start accepted at edge k.
  - Iterations occur at edges k+1 through k+WIDTH.
  - done is high for exactly the cycle between edges k+WIDTH and k+WIDTH+1.
  - The next start can be accepted at edge k+WIDTH+2, giving a throughput of one result per WIDTH+2 cycles.
- product:
  - Registered output, written only at the RUN→DONE transition.
  - Unchanged by start, abort, or new operands.
- start outside IDLE is ignored; there is no queuing.
- Operands are don't-care except at the accepting edge; changing them mid-RUN has no effect.
- abort:
  - In RUN or DONE, abort=1 at an edge forces IDLE and clears count and the accumulator.
  - No done pulse is produced and product keeps its previous value.
  - If abort coincides with the final RUN iteration, abort wins: product is not written and done stays 0.
  - In IDLE, abort has priority over start; the operation is not accepted.
- Arithmetic:
  - Unsigned only.
  - Maximum result (2^WIDTH-1)^2 fits in 2*WIDTH bits; no overflow is possible.
  - The WIDTH+1-bit partial sum carry must never be dropped.
- aclr asserted mid-RUN: immediate return to the reset values; no partial product is ever visible on product.

Test Plan:
- Reset then idle: aclr low for 2 cycles, start=0 -> product=0x0000, done=0, busy=0 throughout.
- Basic multiply: A=13, B=11, start pulsed at edge k -> busy high from edge k; done high only in the cycle after edge k+8; product=143 (0x008F).
- Full-scale carry: A=0xFF, B=0xFF -> product=0xFE01. Then A=0x80, B=0x02 -> 0x0100. Then A=0x00, B=0xFF -> 0x0000; done still pulses.
- Back-to-back:
  - Hold start=1 continuously with A=3, B=5, then A=7, B=9 presented from the DONE cycle onward.
  - Required: first done gives 15; the second operation is accepted only at the edge after returning to IDLE; second done gives 63.
  - Operand changes during RUN do not alter either result.
- Abort:
  - Start A=200, B=100 after a prior result of 143; assert abort at the 4th RUN edge -> returns to IDLE with no done pulse and product remains 143.
  - Repeat with abort coinciding with the final iteration -> same outcome.
- Async reset mid-operation: drop aclr between edges during RUN -> product, busy, done go to 0 without waiting for clk. After release, A=6, B=7 completes with 42 and done after 8 cycles.
